// File: rtl/wb_apb_bridge_if.sv
// wb_apb_bridge_if: Wishbone-classic slave and APB4 master signal bundle of wb_apb_bridge
interface wb_apb_bridge_if #(parameter int NSLV = 4);
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [31:0]       wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [3:0]        wb_sel_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;
    logic [31:0]       paddr;
    logic [31:0]       pwdata;
    logic              pwrite;
    logic [3:0]        pstrb;
    logic [NSLV-1:0]   psel;
    logic              penable;
    logic [32*NSLV-1:0] prdata_i;
    logic [NSLV-1:0]   pready_i;
    logic [NSLV-1:0]   pslverr_i;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  prdata_i, pready_i, pslverr_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output paddr, pwdata, pwrite, pstrb, psel, penable
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output prdata_i, pready_i, pslverr_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  paddr, pwdata, pwrite, pstrb, psel, penable
    );
endinterface

// File: rtl/wb_apb_bridge.sv
// wb_apb_bridge: Wishbone classic slave to APB4 master bridge with slot decode and pready timeout
module wb_apb_bridge #(
    parameter int          NSLV       = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          REGION_LSB = 16,
    parameter int          SLOT_LSB   = 12,
    parameter int          TIMEOUT    = 255
) (
    input logic            pclk,
    input logic            presetn,
    wb_apb_bridge_if.slave bus
);
    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state;
    logic [SW-1:0] idx;
    logic [15:0]   cnt;
    logic [SW-1:0] slot;
    logic          hit;
    logic          req;
    logic          rdy;
    logic          serr;
    logic [31:0]   rdata;

    always_comb begin
        slot  = (NSLV > 1) ? bus.wb_adr_i[SLOT_LSB +: SW] : '0;
        hit   = bus.wb_adr_i[31:REGION_LSB] == BASE_ADDR[31:REGION_LSB] && int'(slot) < NSLV;
        req   = bus.wb_cyc_i && bus.wb_stb_i && !bus.wb_ack_o && !bus.wb_err_o;
        rdy   = bus.pready_i[idx];
        serr  = bus.pslverr_i[idx];
        rdata = bus.prdata_i[32*idx +: 32];
    end

    // Completion is reported only if the master still holds cyc; the APB side always finishes
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            bus.wb_dat_o <= '0;
            bus.wb_ack_o <= 1'b0;
            bus.wb_err_o <= 1'b0;
            bus.paddr    <= '0;
            bus.pwdata   <= '0;
            bus.pwrite   <= 1'b0;
            bus.pstrb    <= '0;
            bus.psel     <= '0;
            bus.penable  <= 1'b0;
        end else begin
            bus.wb_ack_o <= 1'b0;
            bus.wb_err_o <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    if (hit) begin
                        state      <= SETUP;
                        idx        <= slot;
                        cnt        <= '0;
                        bus.psel   <= NSLV'(1) << slot;
                        bus.paddr  <= bus.wb_adr_i;
                        bus.pwrite <= bus.wb_we_i;
                        bus.pwdata <= bus.wb_we_i ? bus.wb_dat_i : bus.pwdata;
                        bus.pstrb  <= bus.wb_we_i ? bus.wb_sel_i : 4'h0;
                    end else begin
                        state        <= RESP;
                        bus.wb_err_o <= 1'b1;
                        bus.wb_dat_o <= '0;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                end
                ACCESS: if (rdy || cnt == 16'(TIMEOUT - 1)) begin
                    state        <= IDLE;
                    bus.psel     <= '0;
                    bus.penable  <= 1'b0;
                    bus.wb_ack_o <= bus.wb_cyc_i && rdy && !serr;
                    bus.wb_err_o <= bus.wb_cyc_i && (!rdy || serr);
                    bus.wb_dat_o <= !rdy ? '0 : bus.pwrite ? bus.wb_dat_o : rdata;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                RESP: state <= IDLE;
            endcase
        end
    end
endmodule
